apb_pwm_array: RTL and testbench

APB_PWM_ARRAY -- requirements
Module: apb_pwm_array

---
 rtl/apb_pwm_array.sv | 174 +++++++++++++++++
 tb/tb_apb_pwm_array.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_pwm_array.sv
`timescale 1ns/1ps
// APB3 slave with NUM_CH shadow-buffered PWM channels sharing one period counter,
// plus a synchronized IR-hit detector with a sticky flag, saturating count and level IRQ.
module apb_pwm_array #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 21
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              hit_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              FABINT
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PERIOD = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h08;
  localparam logic [7:0] A_CNT    = 8'h0C;
  localparam logic [5:0] W_DUTY_LAST = 6'(NUM_CH + 3);

  logic              r_en, r_irq_en;
  logic [NUM_CH-1:0] r_ch_en;
  logic [CNT_W-1:0]  r_period, r_period_sh, r_cnt;
  logic [CNT_W-1:0]  r_duty    [NUM_CH];
  logic [CNT_W-1:0]  r_duty_sh [NUM_CH];
  logic [1:0]        r_sync;
  logic              r_sync_d, r_hit, r_fabint;
  logic [7:0]        r_hit_cnt;
  logic [NUM_CH-1:0] r_pwm;

  logic [7:0]  w_off;
  logic [5:0]  w_word;
  logic        w_is_duty, w_mapped, w_bad, w_access, w_wr_ok;
  logic        w_wrap, w_hit_edge, w_clr, w_hit_nxt, w_irq_nxt;
  logic [7:0]  w_hit_cnt_nxt;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_off     = PADDR[7:0];
  assign w_word    = w_off[7:2];
  assign w_is_duty = (w_off[1:0] == 2'b00) && (w_word >= 6'd4) && (w_word <= W_DUTY_LAST);
  assign w_mapped  = w_is_duty || (w_off == A_CTRL) || (w_off == A_PERIOD) ||
                     (w_off == A_STATUS) || (w_off == A_CNT);
  assign w_bad     = !w_mapped || (PWRITE && (w_off == A_CNT));
  assign w_access  = PSEL && PENABLE;
  assign w_wr_ok   = w_access && PWRITE && !w_bad;
  assign w_unused  = ^{PADDR[31:8], PWDATA[31:CNT_W]};

  assign PREADY  = 1'b1;
  assign PSLVERR = w_access && w_bad;
  assign PRDATA  = w_bad ? 32'h0000_0000 : w_rdata;
  assign pwm_out = r_pwm;
  assign FABINT  = r_fabint;

  // Software-visible control, period and duty registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_ch_en  <= '0;
      r_period <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
    end else if (w_wr_ok) begin
      case (w_off)
        A_CTRL: begin
          r_en     <= PWDATA[0];
          r_irq_en <= PWDATA[1];
          r_ch_en  <= PWDATA[8 +: NUM_CH];
        end
        A_PERIOD: r_period <= PWDATA[CNT_W-1:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++)
        if (w_is_duty && (w_word == 6'(i + 4))) r_duty[i] <= PWDATA[CNT_W-1:0];
    end
  end

  assign w_wrap = (r_cnt == r_period_sh);

  // Period counter; shadows follow the live registers while disabled and reload only at wrap.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt       <= '0;
      r_period_sh <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= '0;
    end else if (!r_en || w_wrap) begin
      r_cnt       <= '0;
      r_period_sh <= r_period;
      for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= r_duty[i];
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered PWM compare, one cycle behind the counter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        r_pwm[i] <= r_en && r_ch_en[i] && (r_cnt < r_duty_sh[i]);
    end
  end

  assign w_hit_edge = r_sync[1] && !r_sync_d;
  assign w_clr      = w_wr_ok && (w_off == A_STATUS) && PWDATA[0];
  assign w_irq_nxt  = (w_wr_ok && (w_off == A_CTRL)) ? PWDATA[1] : r_irq_en;

  // A hit edge coinciding with a W1C wins and restarts the count at one.
  always_comb begin
    w_hit_nxt     = r_hit;
    w_hit_cnt_nxt = r_hit_cnt;
    if (w_hit_edge) begin
      w_hit_nxt = 1'b1;
      if (w_clr)                      w_hit_cnt_nxt = 8'd1;
      else if (r_hit_cnt != 8'hFF)    w_hit_cnt_nxt = r_hit_cnt + 8'd1;
      else                            w_hit_cnt_nxt = r_hit_cnt;
    end else if (w_clr) begin
      w_hit_nxt     = 1'b0;
      w_hit_cnt_nxt = 8'd0;
    end else begin
      w_hit_nxt     = r_hit;
      w_hit_cnt_nxt = r_hit_cnt;
    end
  end

  // Hit synchronizer, sticky status and interrupt level.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_sync    <= 2'b00;
      r_sync_d  <= 1'b0;
      r_hit     <= 1'b0;
      r_hit_cnt <= 8'd0;
      r_fabint  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], hit_data};
      r_sync_d  <= r_sync[1];
      r_hit     <= w_hit_nxt;
      r_hit_cnt <= w_hit_cnt_nxt;
      r_fabint  <= w_hit_nxt && w_irq_nxt;
    end
  end

  // Read mux; unmapped offsets fall through to zero.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_off)
      A_CTRL: begin
        w_rdata[0]           = r_en;
        w_rdata[1]           = r_irq_en;
        w_rdata[8 +: NUM_CH] = r_ch_en;
      end
      A_PERIOD: w_rdata[CNT_W-1:0] = r_period;
      A_STATUS: begin
        w_rdata[0]    = r_hit;
        w_rdata[15:8] = r_hit_cnt;
      end
      A_CNT: w_rdata[CNT_W-1:0] = r_cnt;
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          w_rdata[CNT_W-1:0] = (w_is_duty && (w_word == 6'(i + 4))) ? r_duty[i] : w_rdata[CNT_W-1:0];
      end
    endcase
  end

endmodule

// File: tb/tb_apb_pwm_array.sv
`timescale 1ns/1ps
// Directed bench for apb_pwm_array: register table, PWM waveform model, hit/IRQ and reset sequences.
module tb_apb_pwm_array;

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE, hit_data;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, FABINT;
  logic [2:0]  pwm_out;

  int n_err = 0;
  int n_chk = 0;

  apb_pwm_array #(.NUM_CH(3), .CNT_W(21)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .hit_data(hit_data), .pwm_out(pwm_out), .FABINT(FABINT)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the access-phase edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        er;
    apb_xfer(1'b1, addr, data, rd, er);
  endtask

  task automatic apb_rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    apb_xfer(1'b0, addr, 32'h0, rd, er);
    check(name, rd, exp);
  endtask

  task automatic hit_pulse();
    hit_data = 1'b1;
    repeat (3) @(negedge PCLK);
    hit_data = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er, rd_mode, exp0;
    int          dsel;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h001F_FFFF, 1'b0};
    vecs[7]  = '{1'b0, 32'h1000_0004, 32'h0000_0000, 32'h001F_FFFF, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0018, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0018, 32'h0000_0000, 32'h0014_5678, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_FF02, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0702, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_001C, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, 32'h0000_000C, 32'h0000_0005, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b1, 32'h0000_001C, 32'h0000_0055, 32'h0000_0000, 1'b1};
    vecs[18] = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[19] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 32'h001F_FFFF, 1'b0};
    vecs[20] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[21] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[22] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 1'b0};

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0; hit_data = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_fabint", 32'(FABINT), 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    check("pready", 32'(PREADY), 32'h1);
    PRESET = 1'b0;
    @(negedge PCLK);

    for (int i = 0; i < 23; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].err));
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
    end

    // PWM run: PERIOD=9, DUTY0=3 (->7 mid-period), DUTY1=0, DUTY2=20, all channels enabled.
    apb_wr(32'h04, 32'd9);
    apb_wr(32'h10, 32'd3);
    apb_wr(32'h14, 32'd0);
    apb_wr(32'h18, 32'd20);
    apb_wr(32'h00, 32'h0000_0701);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0C;
    rd_mode = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      dsel = ((k - 1) >= 40) ? 7 : 3;
      exp0 = (k >= 1) && (((k - 1) % 10) < dsel);
      if (rd_mode) check($sformatf("cnt_k%0d", k), PRDATA, 32'(k % 10));
      check($sformatf("pwm0_k%0d", k), 32'(pwm_out[0]), 32'(exp0));
      check($sformatf("pwm1_k%0d", k), 32'(pwm_out[1]), 32'h0);
      check($sformatf("pwm2_k%0d", k), 32'(pwm_out[2]), 32'(k >= 1));
      rd_mode = 1'b0;
      case (k)
        33: begin PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'd7; end
        34: PENABLE = 1'b1;
        45: begin PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'd3; end
        46: begin
          PENABLE = 1'b1; #1;
          check("wr_cnt_slverr", 32'(PSLVERR), 32'h1);
        end
        50: begin PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h40; end
        51: begin
          PENABLE = 1'b1; #1;
          check("rd40_slverr", 32'(PSLVERR), 32'h1);
          check("rd40_data", PRDATA, 32'h0);
        end
        default: begin
          PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0C;
          rd_mode = 1'b1;
        end
      endcase
      @(negedge PCLK);
    end
    PSEL = 1'b0; PENABLE = 1'b0;

    apb_wr(32'h00, 32'h0000_0700);
    @(negedge PCLK);
    check("dis_pwm", 32'(pwm_out), 32'h0);
    apb_rd_chk("dis_cnt", 32'h0C, 32'h0);

    // Hits with EN=0, IRQ_EN=1.
    apb_wr(32'h00, 32'h0000_0002);
    repeat (3) hit_pulse();
    check("hit3_fabint", 32'(FABINT), 32'h1);
    apb_rd_chk("hit3_status", 32'h08, 32'h0000_0301);
    apb_wr(32'h08, 32'h1);
    check("w1c_fabint", 32'(FABINT), 32'h0);
    apb_rd_chk("w1c_status", 32'h08, 32'h0);

    hit_pulse();
    check("hit1_fabint", 32'(FABINT), 32'h1);
    apb_wr(32'h00, 32'h0);
    check("irqoff_fabint", 32'(FABINT), 32'h0);
    apb_rd_chk("irqoff_status", 32'h08, 32'h0000_0101);
    apb_wr(32'h00, 32'h0000_0002);
    check("irqon_fabint", 32'(FABINT), 32'h1);

    repeat (260) hit_pulse();
    apb_rd_chk("sat_status", 32'h08, 32'h0000_FF01);
    apb_wr(32'h08, 32'h0);
    apb_rd_chk("w0_status", 32'h08, 32'h0000_FF01);

    // W1C access phase lands on the cycle the synchronized edge is seen.
    repeat (2) @(negedge PCLK);
    hit_data = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h1;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    repeat (2) @(negedge PCLK);
    hit_data = 1'b0;
    repeat (4) @(negedge PCLK);
    check("race_fabint", 32'(FABINT), 32'h1);
    apb_rd_chk("race_status", 32'h08, 32'h0000_0101);

    // Asynchronous reset in the middle of a running period.
    apb_wr(32'h04, 32'd9);
    apb_wr(32'h18, 32'd20);
    apb_wr(32'h00, 32'h0000_0403);
    repeat (3) @(negedge PCLK);
    check("pre_rst_pwm", 32'(pwm_out), 32'h4);
    check("pre_rst_fabint", 32'(FABINT), 32'h1);
    #2;
    PRESET = 1'b1;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'h0);
    check("async_rst_fabint", 32'(FABINT), 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (12) @(negedge PCLK);
    check("post_rst_pwm", 32'(pwm_out), 32'h0);
    apb_rd_chk("post_rst_ctrl", 32'h00, 32'h0);
    apb_rd_chk("post_rst_period", 32'h04, 32'h0);
    apb_rd_chk("post_rst_status", 32'h08, 32'h0);
    apb_rd_chk("post_rst_cnt", 32'h0C, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
